// File: rtl/erm16_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : erm16_bus_arbiter_if
// Purpose  : Bundles the ERM16 arbiter's master-side request ports (core and
//            DMA) and the shared memory/IO bus port into a single interface.
// Ports    : cpu_*  - core request/response channel
//            dma_*  - DMA request/response channel (dma_lock = burst priority)
//            mem_*  - external memory/IO bus (addr, wdata, we, ioe, rdata, ack)
//            gnt    - one-hot bus owner, err - timeout flag
// Modports : master - the arbiter itself (drives responses and the bus)
//            slave  - the surrounding system (drives requests and mem_ack)
// Revision : 1.0 - initial release
// ============================================================================
interface erm16_bus_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          cpu_req;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_we;
  logic          cpu_io;
  logic          cpu_ready;
  logic [DW-1:0] cpu_rdata;

  logic          dma_req;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_we;
  logic          dma_io;
  logic          dma_lock;
  logic          dma_ready;
  logic [DW-1:0] dma_rdata;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic          mem_ioe;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  logic [1:0]    gnt;
  logic          err;

  modport master (
    input  cpu_req, cpu_addr, cpu_wdata, cpu_we, cpu_io,
    output cpu_ready, cpu_rdata,
    input  dma_req, dma_addr, dma_wdata, dma_we, dma_io, dma_lock,
    output dma_ready, dma_rdata,
    output mem_addr, mem_wdata, mem_we, mem_ioe,
    input  mem_rdata, mem_ack,
    output gnt, err
  );

  modport slave (
    output cpu_req, cpu_addr, cpu_wdata, cpu_we, cpu_io,
    input  cpu_ready, cpu_rdata,
    output dma_req, dma_addr, dma_wdata, dma_we, dma_io, dma_lock,
    input  dma_ready, dma_rdata,
    input  mem_addr, mem_wdata, mem_we, mem_ioe,
    output mem_rdata, mem_ack,
    input  gnt, err
  );
endinterface
`default_nettype wire

// File: rtl/erm16_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : erm16_bus_arbiter
// Purpose  : Two-master (core, DMA) arbiter and access sequencer for the
//            ERM16 memory/IO bus. Each access is a request/ack transaction
//            with an optional bounded wait (TIMEOUT) and forced termination.
// Ports    : clk, rst (synchronous, active high)
//            bus      - erm16_bus_arbiter_if.master (requests, responses, bus)
// Params   : AW, DW, TIMEOUT (0 = no timeout), MAX_BURST (1..15)
// Macro    : ERM16_ARB_RR_EN - round-robin on simultaneous unlocked requests;
//            undefined gives the core fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module erm16_bus_arbiter #(
  parameter int AW        = 16,
  parameter int DW        = 16,
  parameter int TIMEOUT   = 15,
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                rst,
  erm16_bus_arbiter_if.master bus
);

  localparam int             WW        = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WW-1:0]  TO_VAL    = WW'(TIMEOUT);
  localparam logic [3:0]     BURST_LIM = 4'(MAX_BURST);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CPU  = 2'd1,
    ST_DMA  = 2'd2
  } state_t;

  state_t        state_q,     state_d;
  logic [AW-1:0] mem_addr_q,  mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          mem_we_q,    mem_we_d;
  logic          mem_ioe_q,   mem_ioe_d;
  logic [1:0]    gnt_q,       gnt_d;
  logic          cpu_ready_q, cpu_ready_d;
  logic          dma_ready_q, dma_ready_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] dma_rdata_q, dma_rdata_d;
  logic          err_q,       err_d;
  logic [WW-1:0] wait_q,      wait_d;
  logic [3:0]    burst_q,     burst_d;
  logic          last_lock_q, last_lock_d;  // previous access was a locked DMA access
`ifdef ERM16_ARB_RR_EN
  logic          last_dma_q,  last_dma_d;   // previous owner: 1 = DMA, 0 = core
`endif

  logic w_cpu_vld, w_dma_vld, w_lock_win, w_rr_dma;
  logic w_grant_dma, w_grant_cpu, w_timeout;

  // A master whose ready pulse is high this cycle is not re-granted, so a
  // held request does not retrigger on its own completion.
  assign w_cpu_vld  = bus.cpu_req & ~cpu_ready_q;
  assign w_dma_vld  = bus.dma_req & ~dma_ready_q;
  assign w_lock_win = last_lock_q & (burst_q < BURST_LIM);

`ifdef ERM16_ARB_RR_EN
  assign w_rr_dma = ~last_dma_q;
`else
  assign w_rr_dma = 1'b0;
`endif

  assign w_grant_dma = w_dma_vld & (~w_cpu_vld | w_lock_win | w_rr_dma);
  // While a locked burst still has credit, the core is also held off in the
  // DMA's own ready cycle; otherwise the core would always slip in between
  // two locked DMA accesses and the lock could never take effect.
  assign w_grant_cpu = w_cpu_vld & ~w_grant_dma & ~(w_lock_win & bus.dma_req);

  assign w_timeout = (TIMEOUT != 0) && (wait_q == TO_VAL);

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    mem_ioe_d   = mem_ioe_q;
    gnt_d       = gnt_q;
    cpu_ready_d = 1'b0;
    dma_ready_d = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    err_d       = 1'b0;
    wait_d      = wait_q;
    burst_d     = burst_q;
    last_lock_d = last_lock_q;
`ifdef ERM16_ARB_RR_EN
    last_dma_d  = last_dma_q;
`endif

    case (state_q)
      ST_IDLE: begin
        wait_d = '0;
        if (w_grant_dma) begin
          state_d     = ST_DMA;
          mem_addr_d  = bus.dma_addr;
          mem_wdata_d = bus.dma_wdata;
          mem_we_d    = bus.dma_we;
          mem_ioe_d   = bus.dma_io;
          gnt_d       = 2'b10;
          last_lock_d = bus.dma_lock;
          if (!bus.dma_lock) begin
            burst_d = 4'd0;
          end else if (bus.cpu_req && (burst_q != 4'hF)) begin
            burst_d = burst_q + 4'd1;
          end
`ifdef ERM16_ARB_RR_EN
          last_dma_d  = 1'b1;
`endif
        end else if (w_grant_cpu) begin
          state_d     = ST_CPU;
          mem_addr_d  = bus.cpu_addr;
          mem_wdata_d = bus.cpu_wdata;
          mem_we_d    = bus.cpu_we;
          mem_ioe_d   = bus.cpu_io;
          gnt_d       = 2'b01;
          last_lock_d = 1'b0;
          burst_d     = 4'd0;
`ifdef ERM16_ARB_RR_EN
          last_dma_d  = 1'b0;
`endif
        end
      end

      ST_CPU, ST_DMA: begin
        if (bus.mem_ack || w_timeout) begin
          // A real ack wins over a coincident timeout.
          if (state_q == ST_CPU) begin
            cpu_ready_d = 1'b1;
            cpu_rdata_d = bus.mem_ack ? bus.mem_rdata : '1;
          end else begin
            dma_ready_d = 1'b1;
            dma_rdata_d = bus.mem_ack ? bus.mem_rdata : '1;
          end
          err_d     = ~bus.mem_ack;
          mem_we_d  = 1'b0;
          mem_ioe_d = 1'b0;
          gnt_d     = 2'b00;
          state_d   = ST_IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        mem_we_d  = 1'b0;
        mem_ioe_d = 1'b0;
        gnt_d     = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_ioe_q   <= 1'b0;
      gnt_q       <= 2'b00;
      cpu_ready_q <= 1'b0;
      dma_ready_q <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      err_q       <= 1'b0;
      wait_q      <= '0;
      burst_q     <= 4'd0;
      last_lock_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_ioe_q   <= mem_ioe_d;
      gnt_q       <= gnt_d;
      cpu_ready_q <= cpu_ready_d;
      dma_ready_q <= dma_ready_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
      err_q       <= err_d;
      wait_q      <= wait_d;
      burst_q     <= burst_d;
      last_lock_q <= last_lock_d;
    end
  end

`ifdef ERM16_ARB_RR_EN
  // Reset to DMA so the core wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_dma_q <= 1'b1;
    end else begin
      last_dma_q <= last_dma_d;
    end
  end
`endif

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_ioe   = mem_ioe_q;
  assign bus.gnt       = gnt_q;
  assign bus.cpu_ready = cpu_ready_q;
  assign bus.dma_ready = dma_ready_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dma_rdata = dma_rdata_q;
  assign bus.err       = err_q;

endmodule
`default_nettype wire

// File: doc/erm16_bus_arbiter.md
# erm16_bus_arbiter

Two-master arbiter and access sequencer for the single ERM16 memory/IO bus. It shares the bus between the ERM16 core and a DMA requester, and runs each access as a request/acknowledge transaction with a bounded wait. It sits between the core's address/data/`wrmem`/`ioe` outputs and the external memory port. It returns read data and a one-cycle completion pulse to whichever master owned the access.

## Interface
Parameters:
- `AW`, 16: address width.
- `DW`, 16: data width.
- `TIMEOUT`, 15: maximum cycles waiting for `mem_ack` before forced termination. 0 disables the timeout.
- `MAX_BURST`, 4: maximum consecutive locked DMA accesses while `cpu_req` is pending. Range 1..15.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cpu_req`  in  1  core access request; held until `cpu_ready`.
- `cpu_addr`  in  AW  core address.
- `cpu_wdata`  in  DW  core write data.
- `cpu_we`  in  1  core write (1) / read (0).
- `cpu_io`  in  1  core IO-space access.
- `cpu_ready`  out  1  one-cycle completion pulse to the core.
- `cpu_rdata`  out  DW  read data; valid while `cpu_ready`=1.
- `dma_req`, `dma_addr`, `dma_wdata`, `dma_we`, `dma_io`, `dma_ready`, `dma_rdata`  same widths and meaning as the `cpu_*` ports, for the DMA master.
- `dma_lock`  in  1  DMA requests priority for its next access (burst).
- `mem_addr`  out  AW  bus address.
- `mem_wdata`  out  DW  bus write data.
- `mem_we`  out  1  bus write strobe.
- `mem_ioe`  out  1  bus IO-space select.
- `mem_rdata`  in  DW  bus read data; sampled when `mem_ack`=1.
- `mem_ack`  in  1  bus access complete.
- `gnt`  out  2  one-hot owner: [0] core, [1] DMA; 00 when idle.
- `err`  out  1  one-cycle pulse, coincident with a ready pulse, when an access timed out.

## Operation
- FSM has three states:
  - IDLE: samples requests.
  - CPU_ACC, DMA_ACC: drive the bus and wait for `mem_ack`.
- Arbitration in IDLE:
  - A requester whose ready pulse is high in the current cycle is ignored that cycle. A held `req` therefore does not re-trigger; a request still high one cycle later is a new access.
  - With a single requester, that requester is granted.
  - With simultaneous requests, the core wins, except in two cases:
    - the previous access was DMA with `dma_lock`=1 and `burst_cnt` < `MAX_BURST`; or
    - round-robin is enabled (see Configuration).
- Entering an ACC state:
  - `mem_addr`, `mem_wdata`, `mem_we`, `mem_ioe` and `gnt` are registered from the granted master.
  - The wait counter is cleared.
- `burst_cnt`:
  - increments on each locked DMA grant made while `cpu_req`=1;
  - clears on any core grant, on `dma_lock`=0 at grant time, and on reset.
- In an ACC state with `mem_ack`=1:
  - capture `mem_rdata` into the owner's `*_rdata`;
  - pulse the owner's `*_ready` for one cycle;
  - drop `mem_we`, `mem_ioe` and `gnt` to 0;
  - return to IDLE.
- Timeout: when the wait counter equals `TIMEOUT` (≠0) without `mem_ack`, terminate as above with `*_rdata`=16'hFFFF and `err`=1.
- `mem_ack` in IDLE is ignored.
- `*_rdata` holds its value between completions.
- Reset values:
  - all outputs 0: `gnt`=00, `mem_*`=0, `*_ready`=0, `*_rdata`=0, `err`=0;
  - state IDLE, `burst_cnt`=0;
  - last-owner register = DMA, so the core wins the first tie.
- Reset asserted mid-access aborts it: no ready pulse, and outputs take reset values on the next edge.

## Timing
- Request seen in IDLE at cycle 0 → bus outputs and `gnt` valid from cycle 1.
- `mem_ack` in cycle k ≥ 1 → `*_ready` and `*_rdata` valid in cycle k+1. The state is IDLE in k+1, so a new grant can drive the bus in k+2.
- Minimum access: 2 cycles from request to ready. Back-to-back throughput: one access per 3 cycles.
- Timeout fires in cycle 1+`TIMEOUT` without ack; the ready/err pulse appears in the next cycle.
- `mem_we` is high for exactly the access cycles of a write, never in IDLE.

## Configuration
- `ERM16_ARB_RR_EN` defined:
  - Simultaneous unlocked requests go to the master that did not own the previous access.
  - The DMA lock rule still overrides.
- `ERM16_ARB_RR_EN` undefined:
  - The core has fixed priority on simultaneous unlocked requests.
  - The last-owner register is not used for arbitration.

## Test plan
- Core read after reset: `cpu_req`=1, addr 16'h0040, ack in cycle 1 with rdata 16'hBEEF → `mem_addr`=16'h0040 in cycle 1, `cpu_ready`=1 and `cpu_rdata`=16'hBEEF in cycle 2, `gnt` back to 00 in cycle 2, no second access while `cpu_req` is held in cycle 2.
- Simultaneous core and DMA requests, fixed priority, ack always 1 → core served first, DMA second. With `ERM16_ARB_RR_EN` and both held, grants alternate core, DMA, core.
- DMA locked burst, `MAX_BURST`=4, `cpu_req` held high → four consecutive DMA accesses, then the core is granted; `burst_cnt` returns to 0.
- Timeout, `TIMEOUT`=15, `mem_ack` never asserted → `cpu_ready`=1, `err`=1, `cpu_rdata`=16'hFFFF in cycle 17; `mem_we`=0 from cycle 17.
- Write with 3 wait states: `dma_we`=1, data 16'h1234 → `mem_we`=1 and `mem_wdata`=16'h1234 in cycles 1–4, ack in cycle 4, `dma_ready` in cycle 5.
- Reset in cycle 2 of a write → `mem_we`=0, `gnt`=00 in cycle 3, no `cpu_ready` pulse; a fresh request afterwards completes normally.
